// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_REL = 2'b01,
        PC_IND = 2'b10,
        PC_RSV = 2'b11
    } pc_sel_e;

    typedef enum logic [1:0] {
        REQ  = 2'b00,
        WAIT = 2'b01,
        HOLD = 2'b10,
        ERR  = 2'b11
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory channel: valid/ready request plus response-valid return.
interface instr_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/instr_fetch_next_pc_calc.sv
// Next-PC selection and alignment check; purely combinational.
module next_pc_calc
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] ximm,
    input  logic [31:0] alu_result,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    // Target select; adds wrap modulo 2^32, reserved encoding holds pc and flags an error
    always_comb begin
        next_pc    = pc;
        misaligned = 1'b0;
        case (pc_sel)
            PC_SEQ: begin
                next_pc    = pc + 32'd4;
                misaligned = !is_word_aligned(next_pc);
            end
            PC_REL: begin
                next_pc    = pc + ximm;
                misaligned = !is_word_aligned(next_pc);
            end
            PC_IND: begin
                next_pc    = {alu_result[31:1], 1'b0};
                misaligned = !is_word_aligned(next_pc);
            end
            default: begin
                next_pc    = pc;
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, requests words from instruction memory and holds
// each instruction until the core retires it.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_if.master      imem,
    output logic               instr_valid,
    output logic [31:0]        instruction,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    input  logic               retire,
    input  logic [1:0]         pc_sel,
    input  logic [31:0]        ximm,
    input  logic [31:0]        alu_result,
    output logic               fetch_err
);

    fetch_state_e state_r;
    fetch_state_e state_s;
    logic [31:0]  pc_r;
    logic [31:0]  instr_r;
    logic         err_r;
    logic [31:0]  next_pc_s;
    logic         misaligned_s;
    logic         retire_hold_s;

    next_pc_calc u_next_pc (
        .pc         (pc_r),
        .pc_sel     (pc_sel),
        .ximm       (ximm),
        .alu_result (alu_result),
        .next_pc    (next_pc_s),
        .misaligned (misaligned_s)
    );

    assign retire_hold_s = (state_r == HOLD) && retire;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= REQ;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; ERR is left only through rst
    always_comb begin
        state_s = state_r;
        case (state_r)
            REQ: begin
                if (imem.imem_req_ready) state_s = WAIT;
                else                     state_s = REQ;
            end
            WAIT: begin
                if (imem.imem_rsp_valid) state_s = HOLD;
                else                     state_s = WAIT;
            end
            HOLD: begin
                if (retire) state_s = misaligned_s ? ERR : REQ;
                else        state_s = HOLD;
            end
            ERR:     state_s = ERR;
            default: state_s = ERR;
        endcase
    end

    // FSM outputs; request is masked while rst is asserted
    always_comb begin
        imem.imem_req_valid = 1'b0;
        instr_valid         = 1'b0;
        case (state_r)
            REQ:     imem.imem_req_valid = !rst;
            HOLD:    instr_valid         = 1'b1;
            default: begin
                imem.imem_req_valid = 1'b0;
                instr_valid         = 1'b0;
            end
        endcase
    end

    // PC, held instruction and sticky error; pc only moves on a clean retire
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r    <= RESET_PC;
            instr_r <= NOP_INSTR;
            err_r   <= 1'b0;
        end else begin
            if ((state_r == WAIT) && imem.imem_rsp_valid) begin
                instr_r <= imem.imem_rsp_data;
            end
            if (retire_hold_s && !misaligned_s) begin
                pc_r <= next_pc_s;
            end
            if (retire_hold_s && misaligned_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign imem.imem_addr = pc_r;
    assign pc             = pc_r;
    assign pc_plus4       = pc_r + 32'd4;
    assign instruction    = instr_r;
    assign fetch_err      = err_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a request/hold scoreboard and a simple
// latency-programmable instruction memory model.
module tb_instr_fetch;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        retire;
    logic [1:0]  pc_sel;
    logic [31:0] ximm;
    logic [31:0] alu_result;
    logic        fetch_err;

    always #5 clk = ~clk;

    instr_fetch_if imem_if ();

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (imem_if),
        .instr_valid (instr_valid),
        .instruction (instruction),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .retire      (retire),
        .pc_sel      (pc_sel),
        .ximm        (ximm),
        .alu_result  (alu_result),
        .fetch_err   (fetch_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] ins;
    } hold_t;

    logic [31:0] req_q[$];
    hold_t       hold_q[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[23:0], 8'h13};
    endfunction

    // Memory model: response rsp_lat cycles after acceptance, cleared by rst
    logic        mem_ready;
    int          rsp_lat = 2;
    int          pend = 0;
    logic [31:0] pend_addr = 32'h0;
    int          pulse_req = 0;
    int          pulse_done = 0;

    assign imem_if.imem_req_ready = mem_ready;

    always @(negedge clk) begin
        imem_if.imem_rsp_valid = 1'b0;
        imem_if.imem_rsp_data  = 32'h0;
        if (rst) begin
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    imem_if.imem_rsp_valid = 1'b1;
                    imem_if.imem_rsp_data  = mem_word(pend_addr);
                end
            end
            if (pulse_done != pulse_req) begin
                imem_if.imem_rsp_valid = 1'b1;
                imem_if.imem_rsp_data  = 32'hDEAD_BEEF;
                pulse_done = pulse_req;
            end
            if (imem_if.imem_req_valid && imem_if.imem_req_ready) begin
                pend      = rsp_lat;
                pend_addr = imem_if.imem_addr;
            end
        end
    end

    // Monitor: compare accepted requests and each new held instruction
    logic iv_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst && imem_if.imem_req_valid && imem_if.imem_req_ready) begin
            if (req_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_req: addr %h accepted, none expected", imem_if.imem_addr);
            end else begin
                check32("req_addr", imem_if.imem_addr, req_q.pop_front());
            end
        end
        if (instr_valid && !iv_prev) begin
            if (hold_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_hold: pc %h instr %h, none expected", pc, instruction);
            end else begin
                hold_t e;
                e = hold_q.pop_front();
                check32("hold_pc", pc, e.addr);
                check32("hold_instr", instruction, e.ins);
                check32("hold_pc_plus4", pc_plus4, e.addr + 32'd4);
            end
        end
        iv_prev = instr_valid;
    end

    task automatic expect_fetch(input logic [31:0] a);
        hold_t e;
        e.addr = a;
        e.ins  = mem_word(a);
        req_q.push_back(a);
        hold_q.push_back(e);
    endtask

    task automatic wait_hold(input string name);
        int k = 0;
        while (!instr_valid && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!instr_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: instr_valid %b after %0d cycles, required 1", name, instr_valid, k);
        end
    endtask

    task automatic do_retire(input logic [1:0] sel, input logic [31:0] xi, input logic [31:0] alu);
        retire     = 1'b1;
        pc_sel     = sel;
        ximm       = xi;
        alu_result = alu;
        @(posedge clk); #1;
        retire     = 1'b0;
        pc_sel     = 2'b11;
        ximm       = 32'h1234_5677;
        alu_result = 32'h0000_0777;
    endtask

    initial begin
        int cyc;
        rst        = 1'b1;
        retire     = 1'b0;
        pc_sel     = 2'b00;
        ximm       = 32'h0;
        alu_result = 32'h0;
        mem_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check1("rst_req_valid", imem_if.imem_req_valid, 1'b0);
        check1("rst_instr_valid", instr_valid, 1'b0);
        check1("rst_fetch_err", fetch_err, 1'b0);
        check32("rst_instruction", instruction, NOP_INSTR);
        check32("rst_pc", pc, 32'h0);

        // First fetch and its latency
        expect_fetch(32'h0);
        rst = 1'b0;
        #1;
        check1("first_req_valid", imem_if.imem_req_valid, 1'b1);
        check32("first_addr", imem_if.imem_addr, 32'h0);
        cyc = 0;
        while (!instr_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check32("first_latency", 32'(cyc), 32'd3);
        check32("first_pc_plus4", pc_plus4, 32'h4);

        // Response pulse outside WAIT must not disturb the held word
        pulse_req++;
        repeat (2) @(posedge clk);
        #1;
        check32("spurious_rsp_instr", instruction, 32'h0050_0093);
        check1("spurious_rsp_valid", instr_valid, 1'b1);

        // Indirect jump to 0x100 (alu bit 0 dropped)
        expect_fetch(32'h100);
        do_retire(2'b10, 32'h0, 32'h0000_0101);
        check1("ind_req_valid", imem_if.imem_req_valid, 1'b1);
        check32("ind_addr", imem_if.imem_addr, 32'h100);
        wait_hold("ind");

        // PC-relative with negative immediate
        expect_fetch(32'h0000_00F8);
        do_retire(2'b01, 32'hFFFF_FFF8, 32'h0);
        check32("rel_addr", imem_if.imem_addr, 32'h0000_00F8);
        wait_hold("rel");

        // Jump to top of address space, then sequential wrap with a stalled memory
        expect_fetch(32'hFFFF_FFFC);
        do_retire(2'b10, 32'h0, 32'hFFFF_FFFC);
        wait_hold("top");
        mem_ready = 1'b0;
        expect_fetch(32'h0);
        do_retire(2'b00, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            retire     = 1'b1;
            pc_sel     = 2'b10;
            alu_result = 32'h500;
            check1("stall_req_valid", imem_if.imem_req_valid, 1'b1);
            check32("stall_addr", imem_if.imem_addr, 32'h0);
            @(posedge clk); #1;
        end
        retire = 1'b0;
        check1("stall_instr_valid", instr_valid, 1'b0);
        check32("stall_addr_end", imem_if.imem_addr, 32'h0);
        mem_ready = 1'b1;
        wait_hold("wrap");

        // Reset in the middle of WAIT, then a late response pulse
        req_q.push_back(32'h4);
        do_retire(2'b00, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst       = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        pulse_req++;
        @(posedge clk); #1;
        check32("midrst_pc", pc, 32'h0);
        check1("midrst_instr_valid", instr_valid, 1'b0);
        check32("midrst_instruction", instruction, NOP_INSTR);
        check1("midrst_req_valid", imem_if.imem_req_valid, 1'b1);
        expect_fetch(32'h0);
        mem_ready = 1'b1;
        wait_hold("midrst");

        // Misaligned indirect target: sticky error, no more requests
        do_retire(2'b10, 32'h0, 32'h0000_0203);
        check1("mis_fetch_err", fetch_err, 1'b1);
        check32("mis_pc", pc, 32'h0);
        for (int i = 0; i < 6; i++) begin
            check1("err_req_valid", imem_if.imem_req_valid, 1'b0);
            check1("err_instr_valid", instr_valid, 1'b0);
            @(posedge clk); #1;
        end
        check1("err_sticky", fetch_err, 1'b1);

        // Reset clears the error; reserved pc_sel also faults
        rst = 1'b1;
        @(posedge clk); #1;
        check1("clr_fetch_err", fetch_err, 1'b0);
        expect_fetch(32'h0);
        rst = 1'b0;
        wait_hold("post_err");
        do_retire(2'b11, 32'h0, 32'h0);
        check1("rsv_fetch_err", fetch_err, 1'b1);
        check32("rsv_pc", pc, 32'h0);
        check1("rsv_req_valid", imem_if.imem_req_valid, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check32("req_q_empty", 32'(req_q.size()), 32'd0);
        check32("hold_q_empty", 32'(hold_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
